// File: rtl/qix_snd_cmd_link_pkg.sv
// qix_snd_pkg: shared types and constants for the Qix sound command link.
//   - snd_state_e : handshake FSM states
//   - ADDR_*      : CPU register addresses
//   - ST_BIT_*    : status register bit positions (addr1 read)
//   - CTL_BIT_*   : control bit positions (addr1 write)
//   - max3/pack_status : small helpers used by the top level
package qix_snd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETUP    = 2'd1,
    ST_STROBE   = 2'd2,
    ST_WAIT_ACK = 2'd3
  } snd_state_e;

  localparam logic [1:0] ADDR_CMD    = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_VOL    = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int ST_BIT_EMPTY  = 0;
  localparam int ST_BIT_FULL   = 1;
  localparam int ST_BIT_REPLY  = 2;
  localparam int ST_BIT_BUSY   = 3;
  localparam int ST_BIT_TMO    = 4;
  localparam int ST_BIT_OVF    = 5;
  localparam int ST_BIT_IRQ_EN = 6;

  localparam int CTL_BIT_CLR    = 0;
  localparam int CTL_BIT_IRQ_EN = 6;
  localparam int CTL_BIT_FLUSH  = 7;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    else m = m;
    if (c > m) m = c;
    else m = m;
    return m;
  endfunction

  function automatic logic [7:0] pack_status(
    input logic empty, input logic full, input logic reply_valid,
    input logic busy, input logic tmo, input logic ovf, input logic irq_en);
    logic [7:0] s;
    s = 8'h00;
    s[ST_BIT_EMPTY]  = empty;
    s[ST_BIT_FULL]   = full;
    s[ST_BIT_REPLY]  = reply_valid;
    s[ST_BIT_BUSY]   = busy;
    s[ST_BIT_TMO]    = tmo;
    s[ST_BIT_OVF]    = ovf;
    s[ST_BIT_IRQ_EN] = irq_en;
    return s;
  endfunction

endpackage

// File: rtl/qix_snd_cmd_link_fifo.sv
// qix_snd_cmd_fifo: small synchronous FIFO holding pending sound commands.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_data   write request and byte
//   pop               remove head (ignored when empty)
//   flush             empty the FIFO (wins over push/pop)
//   full, empty, head status flags and head entry
//   push_drop         push refused because the FIFO was full with no pop
// DEPTH must be a power of two so the pointers wrap naturally.
module qix_snd_cmd_fifo
  import qix_snd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic             push_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             pop_acc_s;
  logic             push_acc_s;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == (AW+1)'(0));
  assign head  = mem_q[rd_ptr_q];

  // Pointer, count and storage next-state; a full FIFO still accepts a push
  // when the head leaves in the same cycle.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pop_acc_s  = pop & ~empty;
    push_acc_s = push & (~full | pop_acc_s);
    push_drop  = push & ~push_acc_s;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_acc_s) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_acc_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_acc_s, pop_acc_s})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/qix_snd_cmd_link.sv
// qix_snd_cmd_link: data-CPU side of the Qix sound command link.
// The data CPU queues command bytes; each is driven onto snd_data_out, held
// for a setup time, strobed to the audio board's CA1 (active low), and the
// link then waits for the audio CPU's CA2 acknowledge (falling edge) to
// latch the reply byte. Also holds the stereo volume latch.
// Ports:
//   clk_20m, reset_n            clock, asynchronous active-low reset
//   cs, rw, addr, data_in       single-cycle CPU register access
//   data_out                    CPU read data (combinational from addr)
//   irq                         interrupt, irq_en & (reply_valid | TMO)
//   snd_data_out, snd_data_in   command / reply bytes to/from audio PIA
//   snd_irq_to_snd              strobe to audio CA1, idle high
//   snd_irq_from_snd            acknowledge from audio CA2 (asynchronous)
//   vol_data                    [7:4] left, [3:0] right volume
// Optional: define QIX_SND_TIMEOUT_EN to abandon a command after ACK_TIMEOUT
// cycles in WAIT_ACK (sets TMO). Without it WAIT_ACK waits forever.
module qix_snd_cmd_link
  import qix_snd_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETUP_CYCLES  = 4,
  parameter int STROBE_CYCLES = 44,
  parameter int ACK_TIMEOUT   = 65535
) (
  input  logic       clk_20m,
  input  logic       reset_n,
  input  logic       cs,
  input  logic       rw,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       irq,
  output logic [7:0] snd_data_out,
  input  logic [7:0] snd_data_in,
  output logic       snd_irq_to_snd,
  input  logic       snd_irq_from_snd,
  output logic [7:0] vol_data
);

  // One shared counter times setup, strobe and (optionally) the ack wait.
  localparam int CNT_MAX = max3(SETUP_CYCLES, STROBE_CYCLES, ACK_TIMEOUT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  snd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             strobe_q, strobe_d;
  logic [7:0]       snd_data_q, snd_data_d;
  logic [7:0]       reply_q, reply_d;
  logic             reply_valid_q, reply_valid_d;
  logic             irq_en_q, irq_en_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       vol_q, vol_d;
  logic             irq_q, irq_d;
  logic             ack_meta_q, ack_sync_q, ack_prev_q;

  logic       push_s, flush_s, clr_s, ctl_wr_s, vol_wr_s, reply_rd_s;
  logic       pop_s, reply_load_s, ack_fall_s;
  logic       fifo_full_s, fifo_empty_s, push_drop_s;
  logic [7:0] fifo_head_s;
  logic       tmo_s, tmo_next_s;

  // CPU access decode.
  assign push_s     = cs & ~rw & (addr == ADDR_CMD);
  assign ctl_wr_s   = cs & ~rw & (addr == ADDR_STATUS);
  assign vol_wr_s   = cs & ~rw & (addr == ADDR_VOL);
  assign reply_rd_s = cs &  rw & (addr == ADDR_CMD);
  assign flush_s    = ctl_wr_s & data_in[CTL_BIT_FLUSH];
  assign clr_s      = ctl_wr_s & data_in[CTL_BIT_CLR];

  // Ack is asynchronous: two sync flops plus a history flop for the edge.
  assign ack_fall_s = ack_prev_q & ~ack_sync_q;

  qix_snd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk_20m),
    .rst_n     (reset_n),
    .push      (push_s),
    .push_data (data_in),
    .pop       (pop_s),
    .flush     (flush_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head      (fifo_head_s),
    .push_drop (push_drop_s)
  );

`ifdef QIX_SND_TIMEOUT_EN
  logic tmo_q, tmo_d, tmo_set_s;
`endif

  // Handshake FSM: next state, shared counter, strobe and command byte.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    strobe_d     = strobe_q;
    snd_data_d   = snd_data_q;
    pop_s        = 1'b0;
    reply_load_s = 1'b0;
`ifdef QIX_SND_TIMEOUT_EN
    tmo_set_s    = 1'b0;
`endif
    if (flush_s) begin
      // Flush abandons any in-flight command without a reply.
      state_d  = ST_IDLE;
      cnt_d    = '0;
      strobe_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            snd_data_d = fifo_head_s;
            cnt_d      = '0;
            state_d    = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
            cnt_d    = '0;
            strobe_d = 1'b0;
            state_d  = ST_STROBE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_STROBE: begin
          if (cnt_q == CNT_W'(STROBE_CYCLES - 1)) begin
            cnt_d    = '0;
            strobe_d = 1'b1;
            state_d  = ST_WAIT_ACK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_ACK: begin
          // Ack edges seen in SETUP/STROBE are simply never looked at.
          if (ack_fall_s) begin
            reply_load_s = 1'b1;
            pop_s        = 1'b1;
            cnt_d        = '0;
            state_d      = ST_IDLE;
          end else begin
`ifdef QIX_SND_TIMEOUT_EN
            if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
              tmo_set_s = 1'b1;
              pop_s     = 1'b1;
              cnt_d     = '0;
              state_d   = ST_IDLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
`else
            cnt_d = cnt_q;
`endif
          end
        end
        default: begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          strobe_d = 1'b1;
        end
      endcase
    end
  end

`ifdef QIX_SND_TIMEOUT_EN
  // Sticky timeout flag; a new timeout wins over a same-cycle clear.
  always_comb begin
    if (tmo_set_s) tmo_d = 1'b1;
    else if (clr_s) tmo_d = 1'b0;
    else tmo_d = tmo_q;
  end

  // Timeout flag register.
  always_ff @(posedge clk_20m or negedge reset_n) begin
    if (!reset_n) tmo_q <= 1'b0;
    else tmo_q <= tmo_d;
  end

  assign tmo_s      = tmo_q;
  assign tmo_next_s = tmo_d;
`else
  assign tmo_s      = 1'b0;
  assign tmo_next_s = 1'b0;
`endif

  // CPU-visible registers: reply latch, sticky flags, irq enable, volume.
  always_comb begin
    reply_d = reply_load_s ? snd_data_in : reply_q;
    // A reply landing in the same cycle as a reply read wins.
    if (reply_load_s) reply_valid_d = 1'b1;
    else if (reply_rd_s) reply_valid_d = 1'b0;
    else reply_valid_d = reply_valid_q;
    if (ctl_wr_s) irq_en_d = data_in[CTL_BIT_IRQ_EN];
    else irq_en_d = irq_en_q;
    if (push_drop_s) ovf_d = 1'b1;
    else if (clr_s) ovf_d = 1'b0;
    else ovf_d = ovf_q;
    if (vol_wr_s) vol_d = data_in;
    else vol_d = vol_q;
    irq_d = irq_en_d & (reply_valid_d | tmo_next_s);
  end

  // FSM and register state.
  always_ff @(posedge clk_20m or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      strobe_q      <= 1'b1;
      snd_data_q    <= 8'h00;
      reply_q       <= 8'h00;
      reply_valid_q <= 1'b0;
      irq_en_q      <= 1'b0;
      ovf_q         <= 1'b0;
      vol_q         <= 8'h00;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      strobe_q      <= strobe_d;
      snd_data_q    <= snd_data_d;
      reply_q       <= reply_d;
      reply_valid_q <= reply_valid_d;
      irq_en_q      <= irq_en_d;
      ovf_q         <= ovf_d;
      vol_q         <= vol_d;
      irq_q         <= irq_d;
    end
  end

  // Ack synchronizer and edge-history flops; idle level is high.
  always_ff @(posedge clk_20m or negedge reset_n) begin
    if (!reset_n) begin
      ack_meta_q <= 1'b1;
      ack_sync_q <= 1'b1;
      ack_prev_q <= 1'b1;
    end else begin
      ack_meta_q <= snd_irq_from_snd;
      ack_sync_q <= ack_meta_q;
      ack_prev_q <= ack_sync_q;
    end
  end

  // CPU read mux.
  always_comb begin
    case (addr)
      ADDR_CMD:    data_out = reply_q;
      ADDR_STATUS: data_out = pack_status(fifo_empty_s, fifo_full_s, reply_valid_q,
                                          (state_q != ST_IDLE), tmo_s, ovf_q, irq_en_q);
      ADDR_VOL:    data_out = vol_q;
      ADDR_RSVD:   data_out = 8'h00;
      default:     data_out = 8'h00;
    endcase
  end

  assign snd_data_out   = snd_data_q;
  assign snd_irq_to_snd = strobe_q;
  assign vol_data       = vol_q;
  assign irq            = irq_q;

endmodule
